// File: rtl/add_step_multi.sv
// add_step_multi
//   Multi-channel delayed add-step stage. Each channel delays its enable strobe
//   through a WIDTH-deep shift register and detects the rising edge of the
//   delayed strobe synchronously. On that edge it registers
//   iData + step, with either wrap or saturate arithmetic, a carry-out flag
//   and an update counter.
//
// Ports
//   clk100    : system clock, rising edge
//   rst       : synchronous active-high reset
//   enable    : per-channel strobe (bit c -> channel c)
//   iData     : packed channel data, channel c at [c*DINA_WIDTH +: DINA_WIDTH]
//   step      : unsigned increment, zero-extended, shared by all channels
//   saturate  : 1 = clamp to all-ones on carry, 0 = wrap
//   shEnable  : delayed enable (shift register MSB) per channel
//   oValid    : one-cycle pulse per channel when its result updates
//   oDataAdd  : registered result per channel, same packing as iData
//   oOverflow : carry-out of the channel's most recent update
//   oCount    : per-channel update count since reset (wraps)
module add_step_multi #(
  parameter int unsigned DINA_WIDTH  = 32,
  parameter int unsigned WIDTH       = 3,
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned STEP_WIDTH  = 8,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                            clk100,
  input  logic                            rst,
  input  logic [CHANNELS-1:0]             enable,
  input  logic [CHANNELS*DINA_WIDTH-1:0]  iData,
  input  logic [STEP_WIDTH-1:0]           step,
  input  logic                            saturate,
  output logic [CHANNELS-1:0]             shEnable,
  output logic [CHANNELS-1:0]             oValid,
  output logic [CHANNELS*DINA_WIDTH-1:0]  oDataAdd,
  output logic [CHANNELS-1:0]             oOverflow,
  output logic [CHANNELS*COUNT_WIDTH-1:0] oCount
);

  logic [WIDTH-1:0]       r_shreg [CHANNELS];
  logic [CHANNELS-1:0]    r_shPrev;
  logic [CHANNELS-1:0]    r_valid;
  logic [CHANNELS-1:0]    r_ovf;
  logic [DINA_WIDTH-1:0]  r_data  [CHANNELS];
  logic [COUNT_WIDTH-1:0] r_cnt   [CHANNELS];

  logic [CHANNELS-1:0]    w_top;
  logic [CHANNELS-1:0]    w_rise;
  logic [DINA_WIDTH:0]    w_sum   [CHANNELS];
  logic [DINA_WIDTH:0]    w_step_ext;

  assign w_step_ext = {{(DINA_WIDTH + 1 - STEP_WIDTH){1'b0}}, step};

  always_comb begin
    w_top  = '0;
    w_rise = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      w_top[c]  = r_shreg[c][WIDTH-1];
      // Edge of the delayed strobe, detected in the clk100 domain.
      w_rise[c] = r_shreg[c][WIDTH-1] & ~r_shPrev[c];
      w_sum[c]  = {1'b0, iData[c*DINA_WIDTH +: DINA_WIDTH]} + w_step_ext;
    end
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      r_shPrev <= '0;
      r_valid  <= '0;
      r_ovf    <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        r_shreg[c] <= '0;
        r_data[c]  <= '0;
        r_cnt[c]   <= '0;
      end
    end else begin
      r_shPrev <= w_top;
      r_valid  <= w_rise;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        r_shreg[c] <= {r_shreg[c][WIDTH-2:0], enable[c]};
        if (w_rise[c]) begin
          r_ovf[c]  <= w_sum[c][DINA_WIDTH];
          r_data[c] <= (saturate && w_sum[c][DINA_WIDTH]) ? '1
                                                          : w_sum[c][DINA_WIDTH-1:0];
          r_cnt[c]  <= r_cnt[c] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    oDataAdd = '0;
    oCount   = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      oDataAdd[c*DINA_WIDTH +: DINA_WIDTH]  = r_data[c];
      oCount[c*COUNT_WIDTH +: COUNT_WIDTH]  = r_cnt[c];
    end
  end

  assign shEnable  = w_top;
  assign oValid    = r_valid;
  assign oOverflow = r_ovf;

endmodule

// File: tb/tb_add_step_multi.sv
// tb_add_step_multi
//   Directed bench for add_step_multi with default parameters
//   (DINA_WIDTH=32, WIDTH=3, CHANNELS=4, STEP_WIDTH=8, COUNT_WIDTH=16).
module tb_add_step_multi;

  localparam int DW = 32;
  localparam int CH = 4;
  localparam int CW = 16;

  logic            clk100 = 1'b0;
  logic            rst;
  logic [CH-1:0]   enable;
  logic [CH*DW-1:0] iData;
  logic [7:0]      step;
  logic            saturate;
  logic [CH-1:0]   shEnable;
  logic [CH-1:0]   oValid;
  logic [CH*DW-1:0] oDataAdd;
  logic [CH-1:0]   oOverflow;
  logic [CH*CW-1:0] oCount;

  int checks   = 0;
  int failures = 0;

  add_step_multi #(
    .DINA_WIDTH (DW),
    .WIDTH      (3),
    .CHANNELS   (CH),
    .STEP_WIDTH (8),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk100   (clk100),
    .rst      (rst),
    .enable   (enable),
    .iData    (iData),
    .step     (step),
    .saturate (saturate),
    .shEnable (shEnable),
    .oValid   (oValid),
    .oDataAdd (oDataAdd),
    .oOverflow(oOverflow),
    .oCount   (oCount)
  );

  always #5 clk100 = ~clk100;

  // Advance one edge; inputs and outputs are touched 1 ns after the edge.
  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] dat(input int c);
    return oDataAdd[c*DW +: DW];
  endfunction

  function automatic logic [CW-1:0] cnt(input int c);
    return oCount[c*CW +: CW];
  endfunction

  // Single-cycle pulse on the given channels; returns 1 ns after edge k+3.
  task automatic pulse_and_wait(input logic [CH-1:0] m);
    enable = m;
    tick();
    enable = '0;
    tick();
    tick();
    tick();
  endtask

  int nvalid;
  int nsh;
  int first_v;
  int second_v;
  int seen_valid;

  initial begin
    rst      = 1'b1;
    enable   = '0;
    iData    = '0;
    step     = '0;
    saturate = 1'b0;

    // Reset with enable toggling
    for (int i = 0; i < 3; i++) begin
      enable = (i % 2 == 0) ? 4'b1111 : 4'b0000;
      tick();
    end
    chk("rst_valid", 64'(oValid), 64'h0);
    chk("rst_shen",  64'(shEnable), 64'h0);
    chk("rst_data",  64'(oDataAdd[63:0] | oDataAdd[127:64]), 64'h0);
    chk("rst_ovf",   64'(oOverflow), 64'h0);
    chk("rst_cnt",   oCount, 64'h0);

    rst    = 1'b0;
    enable = '0;
    seen_valid = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (oValid != '0) seen_valid++;
    end
    chk("post_rst_no_valid", 64'(seen_valid), 64'h0);

    // Latency / basic
    iData[31:0] = 32'h0000_0010;
    step        = 8'd1;
    enable = 4'b0001;
    tick();             // edge k
    enable = '0;
    tick();
    tick();             // edge k+2
    chk("lat_shen_k2",  64'(shEnable), 64'h1);
    chk("lat_valid_k2", 64'(oValid), 64'h0);
    tick();             // edge k+3
    chk("basic_valid", 64'(oValid), 64'h1);
    chk("basic_data",  64'(dat(0)), 64'h11);
    chk("basic_ovf",   64'(oOverflow[0]), 64'h0);
    chk("basic_cnt",   64'(cnt(0)), 64'h1);
    tick();
    chk("basic_valid_drop", 64'(oValid), 64'h0);
    chk("basic_data_hold",  64'(dat(0)), 64'h11);

    // Wrap
    iData[31:0] = 32'hFFFF_FFFE;
    step        = 8'd5;
    saturate    = 1'b0;
    pulse_and_wait(4'b0001);
    chk("wrap_data", 64'(dat(0)), 64'h3);
    chk("wrap_ovf",  64'(oOverflow[0]), 64'h1);
    chk("wrap_cnt",  64'(cnt(0)), 64'h2);

    // Saturate
    saturate = 1'b1;
    pulse_and_wait(4'b0001);
    chk("sat_data", 64'(dat(0)), 64'hFFFF_FFFF);
    chk("sat_ovf",  64'(oOverflow[0]), 64'h1);
    chk("sat_cnt",  64'(cnt(0)), 64'h3);

    // step = 0 clears the non-sticky overflow flag
    iData[31:0] = 32'h0000_0005;
    step        = 8'd0;
    saturate    = 1'b0;
    pulse_and_wait(4'b0001);
    chk("step0_valid", 64'(oValid), 64'h1);
    chk("step0_data",  64'(dat(0)), 64'h5);
    chk("step0_ovf",   64'(oOverflow[0]), 64'h0);
    chk("step0_cnt",   64'(cnt(0)), 64'h4);
    tick();

    // Level enable for 10 cycles
    nvalid = 0;
    nsh    = 0;
    for (int i = 0; i < 20; i++) begin
      enable = (i < 10) ? 4'b0001 : 4'b0000;
      tick();
      nvalid += int'(oValid[0]);
      nsh    += int'(shEnable[0]);
    end
    chk("level_one_valid", 64'(nvalid), 64'h1);
    chk("level_shen_len",  64'(nsh), 64'd10);
    chk("level_cnt",       64'(cnt(0)), 64'h5);

    // Pattern 1,0,1: two updates two cycles apart
    first_v  = -1;
    second_v = -1;
    nvalid   = 0;
    for (int i = 0; i < 10; i++) begin
      enable = (i == 0 || i == 2) ? 4'b0001 : 4'b0000;
      tick();           // edge i
      if (oValid[0]) begin
        nvalid++;
        if (first_v < 0) first_v = i;
        else second_v = i;
      end
    end
    chk("pat_nvalid", 64'(nvalid), 64'h2);
    chk("pat_first",  64'(first_v), 64'd3);
    chk("pat_second", 64'(second_v), 64'd5);
    chk("pat_cnt",    64'(cnt(0)), 64'h7);

    // Multi-channel simultaneous update
    iData[0*DW +: DW] = 32'h1;
    iData[1*DW +: DW] = 32'h2;
    iData[2*DW +: DW] = 32'h3;
    iData[3*DW +: DW] = 32'h4;
    step = 8'h10;
    pulse_and_wait(4'b1111);
    chk("mc_valid", 64'(oValid), 64'hF);
    chk("mc_d0", 64'(dat(0)), 64'h11);
    chk("mc_d1", 64'(dat(1)), 64'h12);
    chk("mc_d2", 64'(dat(2)), 64'h13);
    chk("mc_d3", 64'(dat(3)), 64'h14);
    chk("mc_ovf", 64'(oOverflow), 64'h0);
    chk("mc_cnt0", 64'(cnt(0)), 64'h8);
    chk("mc_cnt3", 64'(cnt(3)), 64'h1);
    tick();

    // Reset one cycle after an enable pulse
    enable = 4'b0010;
    tick();
    enable = '0;
    rst    = 1'b1;
    tick();
    rst = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (oValid != '0) seen_valid++;
    end
    chk("midrst_no_valid", 64'(seen_valid), 64'h0);
    chk("midrst_cnt",      oCount, 64'h0);
    chk("midrst_data1",    64'(dat(1)), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
